// File: rtl/alu_result_collector_pkg.sv
// Shared parameters for the ALU result path and the result collector.
package parameters;

    localparam int unsigned RESULT_BUS_WIDTH = 32;
    localparam int unsigned MAX_BEATS        = 4;
    localparam int unsigned BEAT_CNT_W       = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } collector_state_e;

endpackage

// File: rtl/alu_result_collector_result_hold_reg.sv
// Output holding register: valid/ready handshake plus overflow detection
// when a new result arrives while the previous one is still unclaimed.
module result_hold_reg #(
    parameter int unsigned DW = 128,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic [CW-1:0] load_beats_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] beats_o,
    output logic          overflow_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          overflow_q, overflow_d;
    logic          handshake_c;

    // Next-state: refill when empty or freed this cycle, otherwise drop and flag.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        beats_d     = beats_q;
        overflow_d  = 1'b0;
        handshake_c = valid_q & ready_i;
        if (load_i) begin
            if (!valid_q || handshake_c) begin
                valid_d = 1'b1;
                data_d  = load_data_i;
                beats_d = load_beats_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (handshake_c) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            beats_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            beats_q    <= beats_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign beats_o    = beats_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects multi-beat ALU result bursts (LSB beat first) into one wide word
// and hands it to the writeback side over a valid/ready port.
module alu_result_collector #(
    parameter int unsigned RESULT_BUS_WIDTH = parameters::RESULT_BUS_WIDTH,
    parameter int unsigned MAX_BEATS        = parameters::MAX_BEATS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  result_valid,
    input  logic [RESULT_BUS_WIDTH-1:0]           result,
    input  logic                                  result_last,
    input  logic                                  result_rst,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MAX_BEATS*RESULT_BUS_WIDTH-1:0] out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0]        out_beats,
    output logic                                  err_overlen,
    output logic                                  err_overflow,
    output logic                                  abort_pulse
);
    import parameters::*;

    localparam int unsigned W  = RESULT_BUS_WIDTH;
    localparam int unsigned N  = MAX_BEATS;
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);
    localparam int unsigned DW = MAX_BEATS * RESULT_BUS_WIDTH;

    collector_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             err_overlen_q, err_overlen_d;
    logic             abort_q, abort_d;

    logic [DW-1:0]    beat_word_c;
    logic             complete_c;
    logic [DW-1:0]    cmp_data_c;
    logic [CW-1:0]    cmp_beats_c;

    // Accumulator FSM: place beats, detect completion, overlength and aborts.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        err_overlen_d = 1'b0;
        abort_d       = 1'b0;
        complete_c    = 1'b0;
        cmp_data_c    = '0;
        cmp_beats_c   = '0;

        beat_word_c = acc_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                beat_word_c[k*W +: W] = result;
            end
        end

        case (state_q)
            IDLE: begin
                // result_rst wins over a coincident beat, even with nothing to abort
                if (!result_rst && result_valid) begin
                    if (result_last) begin
                        complete_c  = 1'b1;
                        cmp_data_c  = DW'(result);
                        cmp_beats_c = CW'(1);
                    end else begin
                        acc_d   = DW'(result);
                        cnt_d   = CW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (result_rst) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (result_valid) begin
                    if (cnt_q == CW'(N)) begin
                        err_overlen_d = 1'b1;
                        acc_d         = '0;
                        cnt_d         = '0;
                        state_d       = result_last ? IDLE : DISCARD;
                    end else if (result_last) begin
                        complete_c  = 1'b1;
                        cmp_data_c  = beat_word_c;
                        cmp_beats_c = cnt_q + CW'(1);
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = beat_word_c;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DISCARD: begin
                if (result_rst) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (result_valid && result_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator state and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            err_overlen_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            err_overlen_q <= err_overlen_d;
            abort_q       <= abort_d;
        end
    end

    assign err_overlen = err_overlen_q;
    assign abort_pulse = abort_q;

    result_hold_reg #(
        .DW (DW),
        .CW (CW)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load_i       (complete_c),
        .load_data_i  (cmp_data_c),
        .load_beats_i (cmp_beats_c),
        .ready_i      (out_ready),
        .valid_o      (out_valid),
        .data_o       (out_data),
        .beats_o      (out_beats),
        .overflow_o   (err_overflow)
    );

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector with a burst-level reference model.
module tb_alu_result_collector;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int DW = W * N;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          result_valid;
    logic [W-1:0]  result;
    logic          result_last;
    logic          result_rst;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_beats;
    logic          err_overlen;
    logic          err_overflow;
    logic          abort_pulse;

    always #5 clk = ~clk;

    alu_result_collector #(
        .RESULT_BUS_WIDTH (W),
        .MAX_BEATS        (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .result_last  (result_last),
        .result_rst   (result_rst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_beats    (out_beats),
        .err_overlen  (err_overlen),
        .err_overflow (err_overflow),
        .abort_pulse  (abort_pulse)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int tag;
        bit v;
        bit ovf;
        bit ol;
        bit ab;
        bit z;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] b;
    } res_t;

    exp_t       exp_q[$];
    res_t       res_q[$];

    // Reference model state: the beats of the open burst, discard mode, holding flag.
    logic [W-1:0] burst[$];
    bit           discarding = 1'b0;
    bit           held = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Drive one cycle of inputs, advance the model, then step past the clock edge.
    task automatic step(input bit r, input bit v, input logic [W-1:0] d,
                        input bit l, input bit rr, input bit rdy);
        exp_t e;
        res_t nr;
        bit   hs;
        bit   done;
        rst          = r;
        result_valid = v;
        result       = d;
        result_last  = l;
        result_rst   = rr;
        out_ready    = rdy;

        e.tag = cyc + 1;
        e.v = 1'b0; e.ovf = 1'b0; e.ol = 1'b0; e.ab = 1'b0; e.z = 1'b0;
        nr.d = '0;
        nr.b = '0;
        done = 1'b0;
        hs   = held && rdy;
        if (r) begin
            // an unclaimed held result will never be seen by the monitor
            if (held && !rdy) void'(res_q.pop_back());
            burst.delete();
            discarding = 1'b0;
            held = 1'b0;
            e.z = 1'b1;
        end else begin
            if (rr) begin
                if (burst.size() != 0 || discarding) e.ab = 1'b1;
                burst.delete();
                discarding = 1'b0;
            end else if (v) begin
                if (discarding) begin
                    if (l) discarding = 1'b0;
                end else if (burst.size() == N) begin
                    e.ol = 1'b1;
                    burst.delete();
                    discarding = !l;
                end else begin
                    burst.push_back(d);
                    if (l) begin
                        foreach (burst[k]) nr.d[k*W +: W] = burst[k];
                        nr.b = CW'(burst.size());
                        done = 1'b1;
                        burst.delete();
                    end
                end
            end
            if (done) begin
                if (!held || hs) begin
                    held = 1'b1;
                    res_q.push_back(nr);
                end else begin
                    e.ovf = 1'b1;
                end
            end else if (hs) begin
                held = 1'b0;
            end
        end
        e.v = held;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic beat(input logic [W-1:0] d, input bit l, input bit rdy);
        step(1'b0, 1'b1, d, l, 1'b0, rdy);
    endtask

    // Monitor: per-cycle status checks and scoreboard pop on each handshake.
    initial begin
        exp_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                e = exp_q.pop_front();
                check("out_valid",    DW'(out_valid),    DW'(e.v));
                check("err_overflow", DW'(err_overflow), DW'(e.ovf));
                check("err_overlen",  DW'(err_overlen),  DW'(e.ol));
                check("abort_pulse",  DW'(abort_pulse),  DW'(e.ab));
                if (e.z) begin
                    check("reset_out_data",  out_data,        '0);
                    check("reset_out_beats", DW'(out_beats),  '0);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (res_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got data %0h beats %0d expected no result (cycle %0d)",
                             out_data, out_beats, cyc);
                end else begin
                    r = res_q.pop_front();
                    check("out_data",  out_data,        r.d);
                    check("out_beats", DW'(out_beats),  DW'(r.b));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; result_valid = 1'b0; result = '0;
        result_last = 1'b0; result_rst = 1'b0; out_ready = 1'b0;

        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // three-beat burst, held one cycle before acceptance
        beat(32'h11, 1'b0, 1'b0);
        beat(32'h22, 1'b0, 1'b0);
        beat(32'h33, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // single beat with the consumer always ready
        beat(32'hDEADBEEF, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // overlength burst, then a good two-beat burst
        for (int i = 1; i <= 5; i++) beat(W'(i), (i == 5), 1'b1);
        beat(32'h66, 1'b0, 1'b1);
        beat(32'h77, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // abort with a coincident valid beat, then a fresh burst
        beat(32'h1, 1'b0, 1'b1);
        beat(32'h2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
        beat(32'hA, 1'b0, 1'b1);
        beat(32'hB, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // overflow while held, then refill on a same-cycle handshake
        beat(32'h1, 1'b1, 1'b0);
        idle(1'b0);
        beat(32'h2, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        beat(32'h1, 1'b1, 1'b0);
        idle(1'b0);
        beat(32'h2, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset with a held result and a partial burst
        beat(32'h7, 1'b1, 1'b0);
        beat(32'h8, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        beat(32'hC, 1'b0, 1'b1);
        beat(32'hD, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // randomized traffic
        repeat (3000) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 65,
                 $urandom(),
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 60);
        end

        repeat (6) idle(1'b1);
        @(negedge clk);
        check("scoreboard_drained", DW'(res_q.size()), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream consumer of the multi-cycle ALU result bus (`result_valid`/`result`/`result_last`/`result_rst`). It gathers a burst of result beats, LSB beat first, into one wide result word and presents it on a valid/ready output port. Overlength bursts, completions arriving while the output is still held, and mid-burst aborts are flagged rather than silently lost. It sits between the ALU result bus and the result scoreboard/writeback consumer.

## Interface
- `RESULT_BUS_WIDTH`, default from the `parameters` package: width of one result beat (W).
- `MAX_BEATS`, default 4: maximum beats per burst (N); must be ≥1.
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `result_valid`  in  1  the beat on `result` is valid this cycle.
- `result`  in  W  beat data.
- `result_last`  in  1  final beat of the burst; qualified by `result_valid`.
- `result_rst`  in  1  abort the burst in progress.
- `out_valid`  out  1  assembled result is available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  N*W  assembled result; beat k occupies bits [k*W +: W]; unused upper beats are zero.
- `out_beats`  out  $clog2(N+1)  number of beats in the result (1..N).
- `err_overlen`  out  1  one-cycle pulse: the burst exceeded N beats and was discarded.
- `err_overflow`  out  1  one-cycle pulse: a burst completed while the holding register was occupied; the new result was dropped.
- `abort_pulse`  out  1  one-cycle pulse: a partial burst was cancelled by `result_rst`.

## Operation
- Accumulator state machine has three states: IDLE, COLLECT and DISCARD.
  - IDLE + valid & !last: store beat 0, set cnt=1, go to COLLECT.
  - IDLE + valid & last: complete a 1-beat result immediately.
  - COLLECT + valid: write the beat at index cnt and increment cnt.
    - If last: complete with cnt+1 beats and return to IDLE.
    - If cnt==N (this is beat N+1): pulse `err_overlen`. Go to IDLE if last, otherwise go to DISCARD.
  - DISCARD: ignore beats until valid & last, then return to IDLE.
- `result_rst` has priority over `result_valid` in the same cycle; that beat is dropped.
  - In COLLECT or DISCARD: clear the accumulator and cnt, go to IDLE, and pulse `abort_pulse`.
  - In IDLE: no effect and no pulse.
- Completing a result means copying the zero-extended accumulator and its beat count into the holding register and setting `out_valid`. The accumulator is cleared.
- The holding register is freed when `out_valid & out_ready` (the handshake).
- If a completion and a handshake happen in the same cycle, the holding register is refilled with the new result and no error is raised.
- If a completion happens while the register is held and there is no handshake: keep the old data, drop the new result, pulse `err_overflow`.
- While `out_valid` is high, `out_data` and `out_beats` are stable until the handshake.
- `result_rst` does not touch the holding register.

## Timing
- All outputs are registered. Reset values: `out_valid`=0, `out_data`=0, `out_beats`=0, all error and abort pulses 0, state IDLE, cnt 0.
- Latency: a last beat accepted in cycle T gives `out_valid` high in T+1.
- After a handshake in cycle T, `out_valid` drops in T+1 unless it was refilled in T.
- Error and abort pulses are asserted in the cycle after the triggering input and last exactly one cycle.
- The input side has no backpressure, so every beat must be consumed in the cycle it is presented.
- Reset in mid-operation: the accumulator and the holding register are discarded with no error or abort pulses.

## Structure
- Add to the shared `parameters` package:
  - `MAX_BEATS`
  - a `collector_state_e` enum (IDLE/COLLECT/DISCARD)
  - the `BEAT_CNT_W = $clog2(MAX_BEATS+1)` constant
- One sub-module is natural: `result_hold_reg`, the output holding register with the valid/ready handshake and overflow detection.
- The accumulator FSM stays in the top module.

## Test plan
All scenarios use W=32, N=4.
- Beats 0x11, 0x22, 0x33(last) -> one cycle after the last beat, `out_valid`=1, `out_data`=0x00000000_00000033_00000022_00000011, `out_beats`=3.
- Single beat 0xDEADBEEF with last, `out_ready` held high -> `out_valid` is high for exactly one cycle, `out_beats`=1, upper 96 bits zero.
- Five beats, the fifth with last -> `err_overlen` pulses once, `out_valid` stays 0, and the next 2-beat burst assembles correctly.
- Two beats, then `result_rst` together with a valid beat -> `abort_pulse` pulses once, no output; a following burst 0xA, 0xB(last) gives `out_data`[63:0]=0x0000000B_0000000A.
- `out_ready`=0, two 1-beat bursts 0x1 then 0x2 -> `err_overflow` pulses once and `out_data` holds 0x1. Repeat with the handshake in the same cycle as the second completion -> no error, next `out_data`=0x2.
- `rst` asserted mid-burst and while a result is held -> next cycle all outputs are 0, and a new burst assembles from beat 0.
